// File: rtl/pingpong_addr_gen.sv
// pingpong_addr_gen
// Address generator for a two-bank ping-pong buffer. The bank bits come from
// an external toggle stage; this block supplies the in-bank word counters,
// the bank-swap pulses that drive that stage, a closed-bank count used for
// full/empty stalls, and a per-bank fill length so that early-closed banks
// drain only the words that were actually written.

module pingpong_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wrt_shft_enabler,
  input  logic              rd_shft_enabler,
  input  logic              wrt_req,
  input  logic              wrt_last,
  input  logic              rd_req,
  output logic              wrt_ready,
  output logic [ADDR_W:0]   wrt_addr,
  output logic              rd_valid,
  output logic [ADDR_W:0]   rd_addr,
  output logic              rd_last,
  output logic              chng_wrt_shft,
  output logic              chng_rd_shft,
  output logic [1:0]        full_cnt
);

  localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_MAX  = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    W_FILL = 1'b0,
    W_SWAP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_DRAIN = 1'b0,
    R_SWAP  = 1'b1
  } rd_state_t;

  wr_state_t         wr_state_r;
  wr_state_t         wr_state_nxt_s;
  rd_state_t         rd_state_r;
  rd_state_t         rd_state_nxt_s;

  logic [ADDR_W-1:0] wrt_cnt_r;
  logic [ADDR_W-1:0] wrt_cnt_nxt_s;
  logic [ADDR_W-1:0] rd_cnt_r;
  logic [ADDR_W-1:0] rd_cnt_nxt_s;
  logic [1:0]        full_cnt_r;
  logic [1:0]        full_cnt_nxt_s;

  // Last written index per bank, indexed by the bank bit.
  logic [ADDR_W-1:0] len_r [2];
  logic              len_we_s;

  logic              wrt_ready_s;
  logic              wr_acc_s;
  logic              wr_swap_s;
  logic              rd_valid_s;
  logic              rd_last_s;
  logic              rd_acc_s;
  logic              rd_swap_s;

  // Write side: accept words while a bank is free, close the bank on its
  // final word or on wrt_last, then spend one cycle asking for a bank swap.
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    wrt_cnt_nxt_s  = wrt_cnt_r;
    len_we_s       = 1'b0;
    wrt_ready_s    = 1'b0;
    wr_acc_s       = 1'b0;
    wr_swap_s      = 1'b0;
    case (wr_state_r)
      W_FILL: begin
        wrt_ready_s = (full_cnt_r != 2'd2);
        wr_acc_s    = wrt_req && wrt_ready_s;
        if (wr_acc_s) begin
          if ((wrt_cnt_r == CNT_MAX) || wrt_last) begin
            len_we_s       = 1'b1;
            wrt_cnt_nxt_s  = CNT_ZERO;
            wr_state_nxt_s = W_SWAP;
          end else begin
            wrt_cnt_nxt_s  = wrt_cnt_r + CNT_ONE;
          end
        end else begin
          wrt_cnt_nxt_s = wrt_cnt_r;
        end
      end
      W_SWAP: begin
        wr_swap_s      = 1'b1;
        wr_state_nxt_s = W_FILL;
      end
      default: begin
        wr_state_nxt_s = W_FILL;
      end
    endcase
  end

  // Read side: offer words while any bank is closed, flag the bank's final
  // word against its recorded length, then spend one cycle swapping banks.
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    rd_cnt_nxt_s   = rd_cnt_r;
    rd_valid_s     = 1'b0;
    rd_last_s      = 1'b0;
    rd_acc_s       = 1'b0;
    rd_swap_s      = 1'b0;
    case (rd_state_r)
      R_DRAIN: begin
        rd_valid_s = (full_cnt_r != 2'd0);
        rd_last_s  = rd_valid_s && (rd_cnt_r == len_r[rd_shft_enabler]);
        rd_acc_s   = rd_req && rd_valid_s;
        if (rd_acc_s) begin
          if (rd_last_s) begin
            rd_cnt_nxt_s   = CNT_ZERO;
            rd_state_nxt_s = R_SWAP;
          end else begin
            rd_cnt_nxt_s   = rd_cnt_r + CNT_ONE;
          end
        end else begin
          rd_cnt_nxt_s = rd_cnt_r;
        end
      end
      R_SWAP: begin
        rd_swap_s      = 1'b1;
        rd_state_nxt_s = R_DRAIN;
      end
      default: begin
        rd_state_nxt_s = R_DRAIN;
      end
    endcase
  end

  // Closed-bank count: a write swap adds a bank, a read swap removes one,
  // and both in the same cycle cancel out.
  always_comb begin
    full_cnt_nxt_s = full_cnt_r;
    case ({wr_swap_s, rd_swap_s})
      2'b10:   full_cnt_nxt_s = full_cnt_r + 2'd1;
      2'b01:   full_cnt_nxt_s = full_cnt_r - 2'd1;
      default: full_cnt_nxt_s = full_cnt_r;
    endcase
  end

  // State, counter and closed-bank registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_state_r <= W_FILL;
      rd_state_r <= R_DRAIN;
      wrt_cnt_r  <= CNT_ZERO;
      rd_cnt_r   <= CNT_ZERO;
      full_cnt_r <= 2'd0;
    end else begin
      wr_state_r <= wr_state_nxt_s;
      rd_state_r <= rd_state_nxt_s;
      wrt_cnt_r  <= wrt_cnt_nxt_s;
      rd_cnt_r   <= rd_cnt_nxt_s;
      full_cnt_r <= full_cnt_nxt_s;
    end
  end

  // Record the closing index of the bank currently being written.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      len_r[0] <= CNT_ZERO;
      len_r[1] <= CNT_ZERO;
    end else if (len_we_s) begin
      len_r[wrt_shft_enabler] <= wrt_cnt_r;
    end
  end

  // Output mapping; bank bits are used directly as the address MSB so the
  // address is valid in the same cycle as ready/valid.
  always_comb begin
    wrt_ready     = wrt_ready_s;
    wrt_addr      = {wrt_shft_enabler, wrt_cnt_r};
    rd_valid      = rd_valid_s;
    rd_addr       = {rd_shft_enabler, rd_cnt_r};
    rd_last       = rd_last_s;
    chng_wrt_shft = (wr_state_r == W_SWAP);
    chng_rd_shft  = (rd_state_r == R_SWAP);
    full_cnt      = full_cnt_r;
  end

endmodule

// File: tb/tb_pingpong_addr_gen.sv
// Self-checking bench for pingpong_addr_gen: models the external toggle
// stage, keeps a word-level scoreboard of expected read addresses, and a
// bank-level timing model of stalls, swap pulses and the closed-bank count.

module tb_pingpong_addr_gen;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 200;

  typedef struct {
    logic [AW:0] addr;
    logic        last;
  } rd_exp_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          wrt_shft_enabler;
  logic          rd_shft_enabler;
  logic          wrt_req = 1'b0;
  logic          wrt_last = 1'b0;
  logic          rd_req = 1'b0;
  logic          wrt_ready;
  logic [AW:0]   wrt_addr;
  logic          rd_valid;
  logic [AW:0]   rd_addr;
  logic          rd_last;
  logic          chng_wrt_shft;
  logic          chng_rd_shft;
  logic [1:0]    full_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int      full_m = 0;
  bit      w_dead = 1'b0;
  bit      r_dead = 1'b0;
  bit      model_ok = 1'b0;
  int      w_bank = 0;
  int      w_idx = 0;
  bit      w_close_flag = 1'b0;
  bit      r_close_flag = 1'b0;
  int      both_seen = 0;
  rd_exp_t rq[$];

  pingpong_addr_gen #(.ADDR_W(AW)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .wrt_shft_enabler (wrt_shft_enabler),
    .rd_shft_enabler  (rd_shft_enabler),
    .wrt_req          (wrt_req),
    .wrt_last         (wrt_last),
    .rd_req           (rd_req),
    .wrt_ready        (wrt_ready),
    .wrt_addr         (wrt_addr),
    .rd_valid         (rd_valid),
    .rd_addr          (rd_addr),
    .rd_last          (rd_last),
    .chng_wrt_shft    (chng_wrt_shft),
    .chng_rd_shft     (chng_rd_shft),
    .full_cnt         (full_cnt)
  );

  always #5 clock = ~clock;

  // Toggle stage: flips each bank bit when the matching pulse is sampled.
  always @(posedge clock) begin
    if (!reset_n) begin
      wrt_shft_enabler <= 1'b0;
      rd_shft_enabler  <= 1'b0;
    end else begin
      if (chng_wrt_shft) wrt_shft_enabler <= ~wrt_shft_enabler;
      if (chng_rd_shft)  rd_shft_enabler  <= ~rd_shft_enabler;
    end
  end

  function automatic bit m_ready();
    return !w_dead && (full_m != 2);
  endfunction

  function automatic bit m_valid();
    return !r_dead && (full_m != 0);
  endfunction

  // Status check and write-side scoreboard push.
  always @(negedge clock) begin
    logic [5:0]  exp_st;
    logic [5:0]  act_st;
    logic [AW:0] exp_wa;
    bit          close;
    if (model_ok) begin
      exp_st = {m_ready(), m_valid(), w_dead, r_dead, 2'(full_m)};
      act_st = {wrt_ready, rd_valid, chng_wrt_shft, chng_rd_shft, full_cnt};
      tests++;
      if (act_st !== exp_st) begin
        fails++;
        $display("FAIL status t=%0t rdy/vld/cw/cr/full got %b required %b", $time, act_st, exp_st);
      end
      if (w_dead && r_dead) both_seen++;
    end
    w_close_flag = 1'b0;
    if (!reset_n) begin
      w_bank = 0;
      w_idx  = 0;
      rq.delete();
    end else if (model_ok && m_ready()) begin
      exp_wa = {1'(w_bank), AW'(w_idx)};
      tests++;
      if (wrt_addr !== exp_wa) begin
        fails++;
        $display("FAIL wrt_addr t=%0t got %h required %h", $time, wrt_addr, exp_wa);
      end
      if (wrt_req) begin
        close = (w_idx == DEPTH - 1) || (wrt_last == 1'b1);
        rq.push_back('{addr: exp_wa, last: close});
        w_close_flag = close;
        if (close) begin
          w_bank = 1 - w_bank;
          w_idx  = 0;
        end else begin
          w_idx++;
        end
      end
    end
  end

  // Read monitor: pops the scoreboard on every accepted read.
  always @(negedge clock) begin
    rd_exp_t e;
    r_close_flag = 1'b0;
    if (model_ok && reset_n) begin
      if (m_valid()) begin
        tests++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL rd_queue t=%0t read offered with no written word pending", $time);
        end else begin
          e = rq[0];
          if ({rd_addr, rd_last} !== {e.addr, e.last}) begin
            fails++;
            $display("FAIL rd_word t=%0t got addr=%h last=%b required addr=%h last=%b",
                     $time, rd_addr, rd_last, e.addr, e.last);
          end
          if (rd_req) begin
            r_close_flag = e.last;
            void'(rq.pop_front());
          end
        end
      end else begin
        tests++;
        if (rd_last !== 1'b0) begin
          fails++;
          $display("FAIL rd_last_idle t=%0t got %b required 0", $time, rd_last);
        end
      end
    end
  end

  // Bank-level timing: a close in cycle N swaps in N+1 and counts from N+2.
  always @(posedge clock) begin
    if (!reset_n) begin
      full_m   = 0;
      w_dead   = 1'b0;
      r_dead   = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      full_m = full_m + int'(w_dead) - int'(r_dead);
      if (full_m < 0 || full_m > 2) begin
        tests++;
        fails++;
        $display("FAIL full_range t=%0t model banks=%0d required 0..2", $time, full_m);
      end
      w_dead = w_close_flag;
      r_dead = r_close_flag;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr_word(input logic last);
    int t;
    t = 0;
    wrt_req  = 1'b1;
    wrt_last = last;
    @(negedge clock);
    while (!wrt_ready && t < TMO) begin
      t++;
      @(negedge clock);
    end
    if (t >= TMO) begin
      tests++;
      fails++;
      $display("FAIL wr_timeout t=%0t wrt_ready low for %0d cycles", $time, t);
    end
    @(posedge clock);
    #1;
    wrt_req  = 1'b0;
    wrt_last = 1'b0;
  endtask

  task automatic rd_word();
    int t;
    t = 0;
    rd_req = 1'b1;
    @(negedge clock);
    while (!rd_valid && t < TMO) begin
      t++;
      @(negedge clock);
    end
    if (t >= TMO) begin
      tests++;
      fails++;
      $display("FAIL rd_timeout t=%0t rd_valid low for %0d cycles", $time, t);
    end
    @(posedge clock);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic wr_words(input int n, input logic last_on_final);
    for (int i = 0; i < n; i++) wr_word((i == n - 1) ? last_on_final : 1'b0);
  endtask

  task automatic rd_words(input int n);
    for (int i = 0; i < n; i++) rd_word();
  endtask

  initial begin
    bit wa;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;

    // Full bank of continuous writes
    wr_words(DEPTH, 1'b0);
    idle(3);

    // Second bank fills the buffer; a stalled write resumes after RSWAP
    wr_words(DEPTH, 1'b0);
    idle(4);
    fork
      wr_words(1, 1'b0);
      begin
        idle(5);
        rd_words(DEPTH);
      end
    join
    rd_words(DEPTH);

    // Early close on the fifth word of the bank
    wr_words(3, 1'b0);
    wr_word(1'b1);
    idle(3);
    rd_words(5);
    idle(3);

    // Read request with nothing buffered
    rd_req = 1'b1;
    idle(6);
    rd_req = 1'b0;

    // Bank closed on its first word
    wr_word(1'b1);
    idle(2);
    rd_words(1);
    idle(2);

    // Concurrent stream with simultaneous swaps
    wr_words(DEPTH, 1'b0);
    idle(3);
    fork
      wr_words(DEPTH, 1'b0);
      rd_words(DEPTH);
    join
    idle(3);
    rd_words(DEPTH);
    idle(3);

    // Reset in the middle of filling the second bank
    wr_words(DEPTH, 1'b0);
    wr_words(7, 1'b0);
    idle(1);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    idle(3);

    // Random traffic; a stalled write is held until accepted
    repeat (3000) begin
      @(negedge clock);
      wa = wrt_req && wrt_ready;
      @(posedge clock);
      #1;
      if (!wrt_req || wa) begin
        wrt_req  = ($urandom_range(0, 3) != 0);
        wrt_last = ($urandom_range(0, 7) == 0);
      end
      rd_req = ($urandom_range(0, 3) != 0);
    end
    wrt_req  = 1'b0;
    wrt_last = 1'b0;
    rd_req   = 1'b0;
    idle(4);

    tests++;
    if (both_seen == 0) begin
      fails++;
      $display("FAIL dual_swap cycles with both pulses got %0d required >0", both_seen);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
